// File: rtl/data_sram_ctrl_pkg.sv
// rtl/data_sram_ctrl_pkg.sv - access-type, size and FSM encodings shared by the data sram controller
// Also used by the cache path through data_sram_ctrl_load_align.
package data_sram_ctrl_pkg;

  localparam logic [2:0] MEM_LB  = 3'd0;
  localparam logic [2:0] MEM_LBU = 3'd1;
  localparam logic [2:0] MEM_LH  = 3'd2;
  localparam logic [2:0] MEM_LHU = 3'd3;
  localparam logic [2:0] MEM_LW  = 3'd4;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE
  } state_t;

  function automatic logic [1:0] size_of(input logic [2:0] mem_type);
    case (mem_type)
      MEM_LB, MEM_LBU: return SIZE_BYTE;
      MEM_LH, MEM_LHU: return SIZE_HALF;
      default:         return SIZE_WORD;
    endcase
  endfunction

  // Stores replicate the datum across every lane so the slave can use size/addr alone.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
    case (size)
      SIZE_BYTE: return {4{wdata[7:0]}};
      SIZE_HALF: return {2{wdata[15:0]}};
      default:   return wdata;
    endcase
  endfunction

endpackage

// File: rtl/data_sram_ctrl_if.sv
// rtl/data_sram_ctrl_if.sv - sram-like data bus (req/wr/size/addr/wdata, addr_ok/data_ok)
interface data_sram_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              data_req;
  logic              data_wr;
  logic [1:0]        data_size;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic [DATA_W-1:0] data_rdata;
  logic              data_addr_ok;
  logic              data_data_ok;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_rdata, data_addr_ok, data_data_ok
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_rdata, data_addr_ok, data_data_ok
  );
endinterface

// File: rtl/data_sram_ctrl_load_align.sv
// rtl/data_sram_ctrl_load_align.sv - picks the addressed byte/half out of a read word and extends it
module data_sram_ctrl_load_align
  import data_sram_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  mem_type,
  output logic [31:0] result
);
  logic [31:0] byte_sh;
  logic [31:0] half_sh;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_sh = rdata >> {addr, 3'b000};
  // Halves are selected by addr[1] only; addr[0] is ignored for halfword lanes.
  assign half_sh = rdata >> {addr[1], 4'b0000};
  assign byte_v  = byte_sh[7:0];
  assign half_v  = half_sh[15:0];

  always_comb begin
    result = rdata;
    case (mem_type)
      MEM_LB:  result = {{24{byte_v[7]}}, byte_v};
      MEM_LBU: result = {24'd0, byte_v};
      MEM_LH:  result = {{16{half_v[15]}}, half_v};
      MEM_LHU: result = {16'd0, half_v};
      default: result = rdata;
    endcase
  end
endmodule

// File: rtl/data_sram_ctrl.sv
// rtl/data_sram_ctrl.sv - MEM-stage load/store to sram-like data bus bridge with pipeline stall
// Optional misaligned-access trap enabled by defining DATA_ALIGN_CHECK_EN.
module data_sram_ctrl
  import data_sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [2:0]        mem_type,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              stall_in,
  output logic              mem_stall,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_error,
  data_sram_ctrl_if.master  bus
);
  state_t            state;
  logic              req_r;
  logic              wr_r;
  logic [1:0]        size_r;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [2:0]        type_r;
  logic [DATA_W-1:0] load_r;
  logic [DATA_W-1:0] aligned;
  logic              misaligned;
  logic              access;

`ifdef DATA_ALIGN_CHECK_EN
  assign misaligned = ((size_of(mem_type) == SIZE_HALF) & mem_addr[0])
                    | ((size_of(mem_type) == SIZE_WORD) & (|mem_addr[1:0]));
  assign addr_error = (mem_read | mem_write) & misaligned;
  assign load_data  = addr_error ? '0 : load_r;
`else
  assign misaligned = 1'b0;
  assign addr_error = 1'b0;
  assign load_data  = load_r;
`endif

  assign access    = (mem_read | mem_write) & ~misaligned;
  assign mem_stall = (state != ST_DONE) & (access | (state != ST_IDLE));

  assign bus.data_req   = req_r;
  assign bus.data_wr    = wr_r;
  assign bus.data_size  = size_r;
  assign bus.data_addr  = addr_r;
  assign bus.data_wdata = wdata_r;

  data_sram_ctrl_load_align u_load_align (
    .rdata    (bus.data_rdata),
    .addr     (addr_r[1:0]),
    .mem_type (type_r),
    .result   (aligned)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      req_r   <= 1'b0;
      wr_r    <= 1'b0;
      size_r  <= SIZE_BYTE;
      addr_r  <= '0;
      wdata_r <= '0;
      type_r  <= MEM_LB;
      load_r  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (access) begin
            state   <= ST_REQ;
            req_r   <= 1'b1;
            wr_r    <= mem_write;
            size_r  <= size_of(mem_type);
            addr_r  <= mem_addr;
            wdata_r <= store_lanes(size_of(mem_type), mem_wdata);
            type_r  <= mem_type;
          end
        end
        ST_REQ: begin
          if (bus.data_addr_ok) begin
            req_r <= 1'b0;
            if (bus.data_data_ok) begin
              state  <= ST_DONE;
              load_r <= wr_r ? '0 : aligned;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (bus.data_data_ok) begin
            state  <= ST_DONE;
            load_r <= wr_r ? '0 : aligned;
          end
        end
        ST_DONE: begin
          // The pipeline advances on the same edge that leaves DONE.
          if (!stall_in) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_data_sram_ctrl.sv
// tb/tb_data_sram_ctrl.sv - randomized self-checking bench for data_sram_ctrl with a bus slave model
module tb_data_sram_ctrl;
  logic        clk = 1'b0;
  logic        rstn;
  logic        mem_read, mem_write, stall_in;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, addr_error;
  logic [31:0] load_data;

  int n_tests = 0;
  int n_fail  = 0;

  data_sram_ctrl_if bus ();

  data_sram_ctrl dut (
    .clk        (clk),
    .rstn       (rstn),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_type   (mem_type),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .stall_in   (stall_in),
    .mem_stall  (mem_stall),
    .load_data  (load_data),
    .addr_error (addr_error),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_size(input logic [2:0] ty);
    if (ty <= 3'd1) return 0;
    if (ty <= 3'd3) return 1;
    return 2;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] ty, input logic [31:0] wd);
    int unsigned b, h;
    b = wd & 32'hFF;
    h = wd & 32'hFFFF;
    case (exp_size(ty))
      0:       return b * 32'h0101_0101;
      1:       return h * 32'h0001_0001;
      default: return wd;
    endcase
  endfunction

  function automatic logic [31:0] exp_load(input logic [2:0] ty, input logic [31:0] a, input logic [31:0] rd);
    int unsigned b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (16 * a[1])) & 32'hFFFF;
    case (ty)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return b;
      3'd2:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd3:    return h;
      default: return rd;
    endcase
  endfunction

  function automatic bit is_misal(input logic [2:0] ty, input logic [31:0] a);
`ifdef DATA_ALIGN_CHECK_EN
    return (exp_size(ty) == 1 && (a % 2) != 0) || (exp_size(ty) == 2 && (a % 4) != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic pulse_reset();
    rstn = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; stall_in = 1'b0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One MEM-stage access; the bench plays the slave with alat extra REQ cycles
  // before addr_ok and dlat WAIT cycles before data_ok (0 = same cycle).
  task automatic run_txn(input bit st, input logic [2:0] ty, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input int alat, input int dlat, input int sin);
    int  req_cycles, stall_cycles, wait_cnt;
    bit  accepted, done;
    logic [31:0] exp_ld;
    @(posedge clk); #1;
    mem_read = ~st; mem_write = st; mem_type = ty; mem_addr = a; mem_wdata = wd;
    exp_ld = st ? 32'd0 : exp_load(ty, a, rd);
    if (is_misal(ty, a)) begin
      @(negedge clk);
      check("misal_err", {31'd0, addr_error}, 32'd1);
      check("misal_stall", {31'd0, mem_stall}, 32'd0);
      check("misal_req", {31'd0, bus.data_req}, 32'd0);
      check("misal_load", load_data, 32'd0);
      @(posedge clk); #1;
      mem_read = 1'b0; mem_write = 1'b0;
      @(negedge clk);
      check("misal_noreq", {31'd0, bus.data_req}, 32'd0);
      return;
    end
    req_cycles = 0; stall_cycles = 0; wait_cnt = 0; accepted = 0; done = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      @(negedge clk);
      bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = $urandom;
      if (c == 0) check("addr_error", {31'd0, addr_error}, 32'd0);
      if (!mem_stall) begin
        done = 1;
      end else begin
        stall_cycles++;
        if (bus.data_req) begin
          req_cycles++;
          check("req_addr", bus.data_addr, a);
          check("req_size", {30'd0, bus.data_size}, exp_size(ty));
          check("req_wr", {31'd0, bus.data_wr}, {31'd0, st});
          if (st) check("req_wdata", bus.data_wdata, exp_wdata(ty, wd));
          if (!accepted && req_cycles == alat + 1) begin
            bus.data_addr_ok = 1'b1;
            accepted = 1;
            if (dlat == 0) begin bus.data_data_ok = 1'b1; bus.data_rdata = rd; end
          end
        end else if (accepted) begin
          wait_cnt++;
          if (wait_cnt == dlat) begin bus.data_data_ok = 1'b1; bus.data_rdata = rd; end
        end
      end
    end
    if (!done) begin
      check("timeout", 32'd0, 32'd1);
      pulse_reset();
      return;
    end
    check("req_cycles", req_cycles, alat + 1);
    check("stall_cycles", stall_cycles, 2 + alat + dlat);
    check("load_data", load_data, exp_ld);
    check("done_req", {31'd0, bus.data_req}, 32'd0);
    stall_in = (sin > 0);
    for (int i = 1; i <= sin; i++) begin
      @(negedge clk);
      check("hold_stall", {31'd0, mem_stall}, 32'd0);
      check("hold_load", load_data, exp_ld);
      check("hold_req", {31'd0, bus.data_req}, 32'd0);
      stall_in = (i < sin);
    end
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
    @(negedge clk);
    check("idle_stall", {31'd0, mem_stall}, 32'd0);
    check("idle_req", {31'd0, bus.data_req}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; stall_in = 1'b0;
    mem_type = 3'd0; mem_addr = 32'd0; mem_wdata = 32'd0;
    bus.data_rdata = 32'd0; bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, bus.data_req}, 32'd0);
    check("rst_wr", {31'd0, bus.data_wr}, 32'd0);
    check("rst_size", {30'd0, bus.data_size}, 32'd0);
    check("rst_addr", bus.data_addr, 32'd0);
    check("rst_wdata", bus.data_wdata, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_stall", {31'd0, mem_stall}, 32'd0);
    check("rst_err", {31'd0, addr_error}, 32'd0);
    rstn = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 3'd4, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 2, 0);
    run_txn(1'b0, 3'd0, 32'h203, 32'h0, 32'h80FF_7F01, 1, 1, 0);
    check("lb_fixed", load_data, 32'hFFFF_FF80);
    run_txn(1'b0, 3'd1, 32'h203, 32'h0, 32'h80FF_7F01, 0, 0, 0);
    check("lbu_fixed", load_data, 32'h0000_0080);
    run_txn(1'b1, 3'd2, 32'h102, 32'h1234_ABCD, 32'h0, 0, 0, 0);
    run_txn(1'b0, 3'd4, 32'h104, 32'h0, 32'h0BAD_F00D, 5, 1, 0);
    run_txn(1'b0, 3'd2, 32'h202, 32'h0, 32'h9876_5432, 0, 1, 3);
    check("lh_fixed", load_data, 32'hFFFF_9876);
`ifdef DATA_ALIGN_CHECK_EN
    run_txn(1'b0, 3'd4, 32'h102, 32'h0, 32'h1111_1111, 0, 0, 0);
`endif

    // Reset while the read is in WAIT; the late data_ok must be ignored.
    @(posedge clk); #1;
    mem_read = 1'b1; mem_type = 3'd4; mem_addr = 32'h300;
    @(negedge clk);
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    check("wait_req", {31'd0, bus.data_req}, 32'd0);
    check("wait_stall", {31'd0, mem_stall}, 32'd1);
    rstn = 1'b0; mem_read = 1'b0;
    #1;
    check("arst_req", {31'd0, bus.data_req}, 32'd0);
    check("arst_stall", {31'd0, mem_stall}, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bus.data_data_ok = 1'b1; bus.data_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    bus.data_data_ok = 1'b0;
    check("stray_req", {31'd0, bus.data_req}, 32'd0);
    check("stray_stall", {31'd0, mem_stall}, 32'd0);
    check("stray_load", load_data, 32'd0);

    for (int n = 0; n < 40; n++) begin
      bit          st;
      logic [2:0]  ty;
      st = $urandom_range(0, 1);
      ty = st ? 3'(2 * $urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      run_txn(st, ty, 32'h1000 + $urandom_range(0, 255), $urandom, $urandom,
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/data_sram_ctrl.md
Name: data_sram_ctrl

Overview:
- Sits directly downstream of the pipeline's memory-access stage.
- Turns a load/store request from the MEM stage into a transaction on the data sram-like bus (req/wr/size/addr/wdata with addr_ok/data_ok).
- Generates the MEM-stage stall while the transaction is outstanding.
- Returns aligned, sign/zero-extended load data to the write-back path.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, other values unsupported.

Ports:
- clk  in  1  core clock.
- rstn  in  1  asynchronous active-low reset.
- mem_read  in  1  MEM-stage instruction is a load.
- mem_write  in  1  MEM-stage instruction is a store. Never asserted together with mem_read.
- mem_type  in  3  access type: LB=0, LBU=1, LH=2, LHU=3, LW=4; SB/SH/SW reuse 0/2/4.
- mem_addr  in  32  effective address (ALU result).
- mem_wdata  in  32  store data, right-aligned.
- stall_in  in  1  stall from later stages; holds the DONE state.
- mem_stall  out  1  stall request to the pipeline.
- load_data  out  32  extended load result.
- addr_error  out  1  misaligned access flag.
- data_req  out  1  sram-like request.
- data_wr  out  1  1 = write.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  byte address.
- data_wdata  out  32  lane-replicated write data.
- data_rdata  in  32  read data.
- data_addr_ok  in  1  address accepted.
- data_data_ok  in  1  data returned / write done.

Behaviour:
- One clock, clk. Reset rstn is asynchronous, active-low.
- access = (mem_read | mem_write) & ~misaligned.
- FSM states: IDLE, REQ, WAIT, DONE. Reset state is IDLE.
- Reset values: data_req=0, data_wr=0, data_size=0, data_addr=0, data_wdata=0, load_data=0, mem_stall=0 (combinational, 0 in IDLE with no access), addr_error=0.
- IDLE: if access, register addr/wdata/size/wr/type and go to REQ. mem_stall=1 combinationally in this same cycle.
- REQ: data_req=1. Request fields come from registers and stay stable until data_addr_ok.
  - addr_ok & data_ok in the same cycle → DONE, capture rdata.
  - addr_ok only → WAIT.
  - Neither → stay in REQ.
- WAIT: data_req=0. On data_data_ok → DONE, capture rdata into the rdata register.
- DONE: mem_stall=0 and load_data valid.
  - stall_in=0 → IDLE on the next edge (the pipeline advances on that same edge).
  - stall_in=1 → stay in DONE, with load_data held.
  - The instruction reaching MEM in the cycle after DONE is treated as new.
- mem_stall = (state!=DONE) & (access | state!=IDLE).
- data_size comes from mem_type: 0/1→0, 2/3→1, 4→2. data_addr = full mem_addr (low bits are not cleared).
- Store lanes: SB → {4{wdata[7:0]}}; SH → {2{wdata[15:0]}}; SW → wdata.
- Load extraction uses the registered addr[1:0]:
  - byte = rdata[8*a+7 : 8*a], sign-extended for LB and zero-extended for LBU.
  - half = rdata[16*a[1]+15 : 16*a[1]], sign-extended for LH and zero-extended for LHU.
  - LW passes rdata through.
- Stores return load_data=0.
- data_data_ok arriving in IDLE or DONE is ignored. data_addr_ok arriving outside REQ is ignored.
- Reset mid-transaction: return to IDLE immediately. Any outstanding response is dropped by the IDLE ignore rule.
- Only one outstanding transaction; no pipelining of requests.

Optional Feature:
- DATA_ALIGN_CHECK_EN defined:
  - misaligned = (half & addr[0]) | (word & |addr[1:0]).
  - A misaligned access issues no bus request and does not stall.
  - addr_error=1 combinationally while the access is present; load_data=0.
- Undefined:
  - misaligned=0 and addr_error tied to 0.
  - Every access is issued as-is, and the slave sees the raw low address bits.

Decomposition:
- Shared include data_sram_defs.vh holds:
  - mem_type encodings (MEM_LB..MEM_LW);
  - size encodings (SIZE_BYTE/HALF/WORD);
  - FSM state constants.
- One combinational sub-module, load_align: inputs rdata, addr[1:0] and mem_type; output the extended result. It is reused later by the cache path.

Test Plan:
- LW at 0x100, addr_ok at cycle+1, data_ok at cycle+3 with rdata=0xDEADBEEF → data_req high for exactly 1 cycle with size=2, addr=0x100, wr=0; mem_stall high for 4 cycles; load_data=0xDEADBEEF in DONE.
- LB at 0x203 and LBU at 0x203, rdata=0x80FF7F01 → load_data=0xFFFFFF80 and 0x00000080 respectively.
- SH at 0x102, wdata=0x1234ABCD, addr_ok & data_ok in the same cycle as req → data_wdata=0xABCDABCD, size=1, wr=1; total stall 2 cycles.
- addr_ok held low for 5 cycles → data_req stays high and data_addr stays stable throughout; stall persists; no second request follows acceptance.
- DONE with stall_in=1 for 3 cycles → load_data held, no new data_req; on release, returns to IDLE.
- With DATA_ALIGN_CHECK_EN, LW at 0x102 → addr_error=1, data_req=0, mem_stall=0. rstn pulsed low during WAIT → state IDLE, data_req=0, and a subsequent stray data_ok is ignored.
